clb_cfg_loader: RTL and testbench
=================================

# clb_cfg_loader

Serial configuration loader for the CLB array. Receives a bit-serial configuration stream (preamble, frame count, per-CLB frames with parity) and delivers one 37-bit configuration word per CLB over a single-cycle write strobe. It is the producer side of the CLB configuration interface; each CLB latches its LUT contents, mux selects and flop/latch mode from these words. Sits between the external configuration pin and the array's configuration write bus.

## Interface
Parameters:
- NUM_CLB, default 64: number of CLBs in the array; maximum legal frame count.
- ADDR_W, default 6: CFG_ADDR width, ≥ clog2(NUM_CLB).
- PREAMBLE, default 8'hF2: sync pattern, sent MSB first.

Ports (clock and reset first). One clock; reset is synchronous and active-high.
- K  input  1  clock; everything updates on posedge K.
- RST  input  1  synchronous, active-high reset.
- DIN  input  1  serial configuration data.
- DVALID  input  1  DIN is sampled only in cycles where DVALID=1.
- CFG_WE  output  1  one-cycle write strobe.
- CFG_ADDR  output  ADDR_W  CLB index for the word being written.
- CFG_DATA  output  37  configuration word.
- BUSY  output  1  high from preamble match until DONE or ERR.
- DONE  output  1  sticky; all frames written.
- ERR  output  1  sticky; bad count or parity failure.

## Operation
- CFG_DATA bit map, MSB to LSB: [36] flop/latch mode, [35] DQ mux 2, [34] DQ mux 1, [33:31] G-side input muxes 3,2,1, [30:28] F-side input muxes 3,2,1, [27:26] comb option, [25:24] X/Y mux 6, [23:22] mux 5, [21:20] mux 4 (R), [19:18] mux 3 (clock), [17:16] mux 2 (S), [15:0] LUT memory.
- Stream order: PREAMBLE (8 bits), COUNT (8 bits, MSB first), then COUNT frames. Each frame is 37 data bits (bit 36 first) followed by 1 parity bit. Even parity over all 38 bits.
- States:
  - HUNT: shift DIN into an 8-bit register; on match with PREAMBLE go to LEN. Any bit pattern is accepted, including overlapping matches.
  - LEN: collect 8 bits. COUNT=0 or COUNT>NUM_CLB → ERR; otherwise → FRAME with index=0.
  - FRAME: collect 37 bits into the shift register while accumulating parity; → PAR.
  - PAR: sample the parity bit. Odd total → ERR with no write. Even total → pulse CFG_WE. If index==COUNT−1 → DONE; else index+1 → FRAME.
  - DONE and ERR are terminal until RST; DIN is ignored in both.
- A cycle with DVALID=0 stalls all bit counters and state; DVALID may drop anywhere, including between a frame and its parity bit.
- BUSY=1 in LEN, FRAME and PAR.

## Timing
- Reset values: CFG_WE=0, CFG_ADDR=0, CFG_DATA=0, BUSY=0, DONE=0, ERR=0. Preamble register, counters and parity are cleared; state is HUNT.
- RST mid-stream aborts the stream with no CFG_WE; RST wins over a simultaneous parity sample.
- CFG_WE is high for exactly the one cycle after the posedge that samples a good parity bit. CFG_ADDR and CFG_DATA are valid in that same cycle and hold until the next write.
- DONE rises in the same cycle as the last CFG_WE. ERR rises the cycle after the offending COUNT or parity bit is sampled.
- Throughput is one bit per DVALID cycle. A full load takes 16+38·COUNT valid cycles after the first preamble bit.
- Index arithmetic is unsigned ADDR_W bits and never wraps, because COUNT ≤ NUM_CLB.

## Test plan
- Reset then PREAMBLE F2, COUNT=1, frame 0x03_802A_0116, parity 0 (DVALID=1 throughout) → one CFG_WE with ADDR=0 and DATA=0x03_802A_0116; DONE=1 and BUSY=0 in the same cycle; ERR=0.
- Junk bits 1,0,1 then F2, COUNT=3, frames 0x0_0000_0001 (parity 1), 0x1F_FFFF_FFFF (parity 1), 0x0_0000_0000 (parity 0) → three writes with ADDR 0, 1, 2 and the matching data; DONE after the third write.
- Same as the first scenario but parity bit=1 → no CFG_WE; ERR=1 and stays 1 through 20 further DVALID cycles; DONE=0.
- COUNT=0, and separately COUNT=65 with NUM_CLB=64 → ERR=1, no CFG_WE ever.
- Same as the first scenario with DVALID toggling 1/0 every cycle → identical write, delivered after 54 valid cycles.
- Assert RST at bit 20 of the frame, then send a full COUNT=1 stream → no write before the reset; exactly one correct write afterwards; DONE=1.

Source files
------------

// File: rtl/clb_cfg_loader.sv
// clb_cfg_loader: serial configuration loader feeding the CLB array's config write bus.
// Latency: one CFG_WE per frame, one cycle after the good parity bit is sampled; 16+38*COUNT valid bits per load.
// Backpressure: none; DVALID=0 simply stalls every counter and the state, so the source paces the stream.
//
// Ports:
//   K        clock, all state updates on posedge K
//   RST      synchronous active-high reset
//   DIN      serial configuration data, sampled only when DVALID=1
//   DVALID   qualifies DIN for the current cycle
//   CFG_WE   single-cycle write strobe toward the CLB array
//   CFG_ADDR CLB index of the word being written (holds until the next write)
//   CFG_DATA 37-bit configuration word (holds until the next write)
//   BUSY     high while a stream is being parsed (after preamble, before DONE/ERR)
//   DONE     sticky, every frame written
//   ERR      sticky, illegal frame count or parity failure
//
// CFG_DATA layout, MSB..LSB: [36] flop/latch mode, [35:34] DQ muxes 2,1,
// [33:31] G-side input muxes, [30:28] F-side input muxes, [27:26] comb option,
// [25:16] muxes 6..2 (2 bits each), [15:0] LUT memory.

module clb_cfg_loader #(
   parameter int         NUM_CLB  = 64,
   parameter int         ADDR_W   = 6,
   parameter logic [7:0] PREAMBLE = 8'hF2
) (
   input  logic              K,
   input  logic              RST,
   input  logic              DIN,
   input  logic              DVALID,
   output logic              CFG_WE,
   output logic [ADDR_W-1:0] CFG_ADDR,
   output logic [36:0]       CFG_DATA,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR
);

   // Index/count comparison width: wide enough for both the 8-bit count and
   // index+1 without truncation.
   localparam int CW = (ADDR_W > 8) ? ADDR_W + 1 : 9;

   typedef enum logic [2:0] {
      S_HUNT,
      S_LEN,
      S_FRAME,
      S_PAR,
      S_DONE,
      S_ERR
   } state_t;

   state_t             state, state_nxt;

   // Only the last 7 bits are kept; the incoming bit completes the 8-bit window.
   logic [6:0]         pre_sr, pre_nxt;
   logic [7:0]         count, count_nxt;
   logic [5:0]         bit_cnt, bit_cnt_nxt;
   logic [36:0]        shift_sr, shift_nxt;
   logic               par_acc, par_nxt;
   logic [ADDR_W-1:0]  index, index_nxt;

   logic               we_q, we_nxt;
   logic [ADDR_W-1:0]  addr_q, addr_nxt;
   logic [36:0]        data_q, data_nxt;

   logic [7:0]         cnt_shift;
   logic               count_bad;
   logic [CW-1:0]      idx_inc;
   logic               last_frame;
   logic               pre_match;

   assign cnt_shift  = {count[6:0], DIN};
   assign count_bad  = (cnt_shift == 8'd0) || (32'(cnt_shift) > 32'(NUM_CLB));
   assign idx_inc    = CW'(index) + CW'(1);
   assign last_frame = (idx_inc == CW'(count));
   assign pre_match  = ({pre_sr, DIN} == PREAMBLE);

   // State and datapath registers.
   always_ff @(posedge K) begin
      if (RST) begin
         state    <= S_HUNT;
         pre_sr   <= '0;
         count    <= '0;
         bit_cnt  <= '0;
         shift_sr <= '0;
         par_acc  <= 1'b0;
         index    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         state    <= state_nxt;
         pre_sr   <= pre_nxt;
         count    <= count_nxt;
         bit_cnt  <= bit_cnt_nxt;
         shift_sr <= shift_nxt;
         par_acc  <= par_nxt;
         index    <= index_nxt;
         we_q     <= we_nxt;
         addr_q   <= addr_nxt;
         data_q   <= data_nxt;
      end
   end

   // Next-state and next-datapath logic. Nothing moves unless DVALID is high.
   always_comb begin
      state_nxt   = state;
      pre_nxt     = pre_sr;
      count_nxt   = count;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift_sr;
      par_nxt     = par_acc;
      index_nxt   = index;
      we_nxt      = 1'b0;
      addr_nxt    = addr_q;
      data_nxt    = data_q;

      case (state)
         S_HUNT: begin
            if (DVALID) begin
               pre_nxt = {pre_sr[5:0], DIN};
               if (pre_match) begin
                  state_nxt   = S_LEN;
                  bit_cnt_nxt = '0;
               end
            end
         end

         S_LEN: begin
            if (DVALID) begin
               count_nxt   = cnt_shift;
               bit_cnt_nxt = bit_cnt + 6'd1;
               if (bit_cnt == 6'd7) begin
                  bit_cnt_nxt = '0;
                  if (count_bad) begin
                     state_nxt = S_ERR;
                  end else begin
                     state_nxt = S_FRAME;
                     index_nxt = '0;
                     par_nxt   = 1'b0;
                  end
               end
            end
         end

         S_FRAME: begin
            if (DVALID) begin
               shift_nxt   = {shift_sr[35:0], DIN};
               par_nxt     = par_acc ^ DIN;
               bit_cnt_nxt = bit_cnt + 6'd1;
               if (bit_cnt == 6'd36) begin
                  bit_cnt_nxt = '0;
                  state_nxt   = S_PAR;
               end
            end
         end

         S_PAR: begin
            if (DVALID) begin
               // Even parity over data plus parity bit: any residual one is an error.
               if (par_acc ^ DIN) begin
                  state_nxt = S_ERR;
               end else begin
                  we_nxt   = 1'b1;
                  addr_nxt = index;
                  data_nxt = shift_sr;
                  par_nxt  = 1'b0;
                  if (last_frame) begin
                     state_nxt = S_DONE;
                  end else begin
                     index_nxt = index + ADDR_W'(1);
                     state_nxt = S_FRAME;
                  end
               end
            end
         end

         default: begin
            // S_DONE and S_ERR are terminal until reset; DIN is ignored.
         end
      endcase
   end

   assign CFG_WE   = we_q;
   assign CFG_ADDR = addr_q;
   assign CFG_DATA = data_q;
   assign BUSY     = (state == S_LEN) || (state == S_FRAME) || (state == S_PAR);
   assign DONE     = (state == S_DONE);
   assign ERR      = (state == S_ERR);

endmodule

// File: tb/tb_clb_cfg_loader.sv
module tb_clb_cfg_loader;

   logic        K = 1'b0;
   logic        RST;
   logic        DIN;
   logic        DVALID;
   logic        CFG_WE;
   logic [5:0]  CFG_ADDR;
   logic [36:0] CFG_DATA;
   logic        BUSY;
   logic        DONE;
   logic        ERR;

   clb_cfg_loader #(.NUM_CLB(64), .ADDR_W(6), .PREAMBLE(8'hF2)) dut (
      .K        (K),
      .RST      (RST),
      .DIN      (DIN),
      .DVALID   (DVALID),
      .CFG_WE   (CFG_WE),
      .CFG_ADDR (CFG_ADDR),
      .CFG_DATA (CFG_DATA),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .ERR      (ERR)
   );

   always #5 K = ~K;

   int tests = 0;
   int fails = 0;

   // Valid-cycle counter, advanced on every accepted DIN sample.
   int vcnt = 0;
   always @(posedge K) if (DVALID === 1'b1 && RST === 1'b0) vcnt <= vcnt + 1;

   typedef struct {
      logic [5:0]  a;
      logic [36:0] d;
      logic        dn;
      logic        bz;
      int          vc;
   } wr_t;
   wr_t got_q[$];

   always @(negedge K) begin
      if (CFG_WE === 1'b1) got_q.push_back('{CFG_ADDR, CFG_DATA, DONE, BUSY, vcnt});
   end

   // Stream under test and reference model results.
   bit stream_q[$];
   typedef struct {
      logic [5:0]  a;
      logic [36:0] d;
   } exp_t;
   exp_t exp_q[$];
   bit   exp_done, exp_err, exp_busy;
   int   base_vcnt;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_bits(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) stream_q.push_back(v[i]);
   endtask

   task automatic push_frame(input logic [36:0] d, input bit bad);
      push_bits(d, 37);
      push_bits(64'((^d) ^ bad), 1);
   endtask

   // Reference parser: scan for the sync byte, read the count, then walk
   // 38-bit frames checking even parity over all 38 bits.
   task automatic run_model();
      int          pos;
      logic [7:0]  win;
      int          cnt;
      logic [36:0] d;
      int          ones;
      exp_q.delete();
      exp_done = 0; exp_err = 0; exp_busy = 0;
      pos = -1; win = 8'h00;
      for (int i = 0; i < stream_q.size(); i++) begin
         win = {win[6:0], stream_q[i]};
         if (win == 8'hF2) begin
            pos = i + 1;
            break;
         end
      end
      if (pos < 0) return;
      if (pos + 8 > stream_q.size()) begin exp_busy = 1; return; end
      cnt = 0;
      for (int i = 0; i < 8; i++) cnt = cnt * 2 + int'(stream_q[pos + i]);
      pos += 8;
      if (cnt == 0 || cnt > 64) begin exp_err = 1; return; end
      for (int f = 0; f < cnt; f++) begin
         if (pos + 38 > stream_q.size()) begin exp_busy = 1; return; end
         d = '0;
         for (int i = 0; i < 37; i++) d = {d[35:0], stream_q[pos + i]};
         ones = $countones(d) + int'(stream_q[pos + 37]);
         pos += 38;
         if (ones % 2 != 0) begin exp_err = 1; return; end
         exp_q.push_back('{6'(f), d});
      end
      exp_done = 1;
   endtask

   task automatic cyc(input logic v, input logic d);
      DVALID = v;
      DIN    = d;
      @(posedge K);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      RST = 1'b0;
      got_q.delete();
   endtask

   // mode 0: continuous, 1: valid/idle alternating, 2: random idle gaps
   task automatic drive(input int mode);
      base_vcnt = vcnt;
      foreach (stream_q[i]) begin
         if (mode == 2) repeat ($urandom_range(0, 2)) cyc(1'b0, 1'($urandom));
         cyc(1'b1, stream_q[i]);
         if (mode == 1) cyc(1'b0, 1'($urandom));
      end
      cyc(1'b0, 1'b0);
   endtask

   task automatic check_scn(input string name);
      int n;
      repeat (3) cyc(1'b0, 1'b0);
      run_model();
      check({name, ".nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s.addr%0d", name, i), 64'(got_q[i].a), 64'(exp_q[i].a));
         check($sformatf("%s.data%0d", name, i), 64'(got_q[i].d), 64'(exp_q[i].d));
      end
      check({name, ".done"}, 64'(DONE), 64'(exp_done));
      check({name, ".err"},  64'(ERR),  64'(exp_err));
      check({name, ".busy"}, 64'(BUSY), 64'(exp_busy));
      if (exp_done && got_q.size() > 0) begin
         check({name, ".done_with_we"}, 64'(got_q[got_q.size()-1].dn), 64'd1);
         check({name, ".busy_with_we"}, 64'(got_q[got_q.size()-1].bz), 64'd0);
      end
   endtask

   initial begin
      logic [36:0] rd;
      int          cnt, nfr;

      RST = 1'b1; DIN = 1'b0; DVALID = 1'b0;
      @(posedge K); #1;
      do_reset();
      check("rst.we",   64'(CFG_WE),   64'd0);
      check("rst.addr", 64'(CFG_ADDR), 64'd0);
      check("rst.data", 64'(CFG_DATA), 64'd0);
      check("rst.busy", 64'(BUSY),     64'd0);
      check("rst.done", 64'(DONE),     64'd0);
      check("rst.err",  64'(ERR),      64'd0);

      // Single good frame, continuous valid.
      stream_q.delete();
      push_bits(64'hF2, 8); push_bits(64'd1, 8); push_frame(37'h03_802A_0116, 1'b0);
      drive(0);
      check_scn("one");
      if (got_q.size() > 0) check("one.literal", 64'(got_q[0].d), 64'h03_802A_0116);

      // Junk prefix, three frames with boundary data.
      do_reset();
      stream_q.delete();
      push_bits(64'b101, 3); push_bits(64'hF2, 8); push_bits(64'd3, 8);
      push_frame(37'h0_0000_0001, 1'b0);
      push_frame(37'h1F_FFFF_FFFF, 1'b0);
      push_frame(37'h0_0000_0000, 1'b0);
      drive(0);
      check_scn("three");

      // Bad parity, then 20 more valid bits that must be ignored.
      do_reset();
      stream_q.delete();
      push_bits(64'hF2, 8); push_bits(64'd1, 8); push_frame(37'h03_802A_0116, 1'b1);
      for (int i = 0; i < 20; i++) push_bits(64'($urandom_range(0, 1)), 1);
      drive(0);
      check_scn("badpar");

      // Illegal counts.
      do_reset();
      stream_q.delete();
      push_bits(64'hF2, 8); push_bits(64'd0, 8); push_frame(37'h03_802A_0116, 1'b0);
      drive(0);
      check_scn("cnt0");

      do_reset();
      stream_q.delete();
      push_bits(64'hF2, 8); push_bits(64'd65, 8); push_frame(37'h03_802A_0116, 1'b0);
      drive(0);
      check_scn("cnt65");

      // DVALID toggling: write lands after 54 valid samples.
      do_reset();
      stream_q.delete();
      push_bits(64'hF2, 8); push_bits(64'd1, 8); push_frame(37'h03_802A_0116, 1'b0);
      drive(1);
      check_scn("toggle");
      if (got_q.size() > 0) check("toggle.vcycles", 64'(got_q[0].vc - base_vcnt), 64'd54);

      // Reset at bit 20 of the frame, then a full load.
      do_reset();
      stream_q.delete();
      push_bits(64'hF2, 8); push_bits(64'd1, 8); push_bits(64'h0F0F0, 20);
      drive(0);
      check("abort.busy_before", 64'(BUSY), 64'd1);
      check("abort.nwr_before", 64'(got_q.size()), 64'd0);
      do_reset();
      check("abort.busy_after_rst", 64'(BUSY), 64'd0);
      stream_q.delete();
      push_bits(64'hF2, 8); push_bits(64'd1, 8); push_frame(37'h15_5555_AAAA, 1'b0);
      drive(0);
      check_scn("abort");

      // Reset coinciding with a good parity bit suppresses the write.
      do_reset();
      stream_q.delete();
      rd = 37'h0A_1234_5678;
      push_bits(64'hF2, 8); push_bits(64'd1, 8); push_bits(64'(rd), 37);
      drive(0);
      RST = 1'b1;
      cyc(1'b1, ^rd);
      RST = 1'b0;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      check("rstpar.nwr",  64'(got_q.size()), 64'd0);
      check("rstpar.busy", 64'(BUSY), 64'd0);
      check("rstpar.done", 64'(DONE), 64'd0);

      // Randomized loads with random gaps, junk, counts and parity faults.
      for (int it = 0; it < 10; it++) begin
         do_reset();
         stream_q.delete();
         repeat ($urandom_range(0, 10)) push_bits(64'($urandom_range(0, 1)), 1);
         push_bits(64'hF2, 8);
         case ($urandom_range(0, 7))
            0:       cnt = $urandom_range(0, 1) ? 0 : int'($urandom_range(65, 255));
            default: cnt = $urandom_range(1, 5);
         endcase
         push_bits(64'(cnt), 8);
         nfr = (cnt >= 1 && cnt <= 5) ? cnt : 2;
         for (int f = 0; f < nfr; f++) begin
            rd = 37'({$urandom, $urandom});
            push_frame(rd, $urandom_range(0, 7) == 0);
         end
         repeat (5) push_bits(64'($urandom_range(0, 1)), 1);
         drive(2);
         check_scn($sformatf("rnd%0d", it));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
